// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM download/video arbiter.
// Write FSM state encoding and the FIFO entry width helper.
package sram_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } arb_state_t;

    // One FIFO entry holds {address, byte}.
    function automatic int entry_w(input int addr_w);
        return addr_w + DATA_W;
    endfunction

endpackage

// File: rtl/sram_arb_fifo.sv
// Synchronous FIFO buffering {addr, byte} download entries.
// Ports: clock, reset (sync, active-high), push/din, pop/dout (head), full, empty.
module sram_arb_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // The extra MSB separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the external SRAM between video fetch and buffered download writes.
// Ports: clock, reset, ce, download, ioctl_*, vid_a/vid_q, sram_*, busy, overflow.
// Optional macro SRAM_ARB_OVF_EN compiles in the sticky overflow flag.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15,
    parameter int SRAM_AW    = 21
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    input  logic               download,
    input  logic               ioctl_wr,
    input  logic [ADDR_W-1:0]  ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic [ADDR_W-1:0]  vid_a,
    output logic [7:0]         vid_q,
    output logic               sram_we_n,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [7:0]         sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [7:0]         sram_dq_i,
    output logic               busy,
    output logic               overflow
);

    localparam int EW = entry_w(ADDR_W);

    arb_state_t         state;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [EW-1:0]      head;
    logic [SRAM_AW-1:0] vid_phys;
    logic [SRAM_AW-1:0] head_phys;

    assign push      = download & ioctl_wr;
    // Writes start only right after the video slot, so ce always sees IDLE.
    assign pop       = (state == ST_IDLE) & ce & ~empty;
    assign vid_phys  = {{(SRAM_AW-ADDR_W){1'b0}}, vid_a};
    assign head_phys = {{(SRAM_AW-ADDR_W){1'b0}}, head[EW-1:8]};

    assign vid_q = sram_dq_i;
    assign busy  = ~empty | (state != ST_IDLE);

    sram_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({ioctl_addr, ioctl_dout}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_dq_o  <= '0;
            sram_a     <= vid_phys;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    sram_we_n <= 1'b1;
                    if (pop) begin
                        state      <= ST_SETUP;
                        sram_a     <= head_phys;
                        sram_dq_o  <= head[7:0];
                        sram_dq_oe <= 1'b1;
                    end else begin
                        sram_a     <= vid_phys;
                        sram_dq_oe <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state     <= ST_STROBE;
                    sram_we_n <= 1'b0;
                end
                ST_STROBE: begin
                    state     <= ST_HOLD;
                    sram_we_n <= 1'b1;
                end
                ST_HOLD: begin
                    state      <= ST_IDLE;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_a     <= vid_phys;
                end
                default: begin
                    state      <= ST_IDLE;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_OVF_EN
    logic ovf;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (push & full & ~pop) begin
            ovf <= 1'b1;
        end
    end

    assign overflow = ovf;
`else
    logic unused_full;

    assign unused_full = full;
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: queue-based model plus directed literals.
// Honours SRAM_ARB_OVF_EN when the same define is given to the build.
module tb_sram_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 15;
    localparam int SAW   = 21;
`ifdef SRAM_ARB_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           ce = 1'b0;
    logic           download = 1'b0;
    logic           ioctl_wr = 1'b0;
    logic [AW-1:0]  ioctl_addr = '0;
    logic [7:0]     ioctl_dout = '0;
    logic [AW-1:0]  vid_a = '0;
    logic [7:0]     vid_q;
    logic           sram_we_n;
    logic [SAW-1:0] sram_a;
    logic [7:0]     sram_dq_o;
    logic           sram_dq_oe;
    logic [7:0]     sram_dq_i = '0;
    logic           busy;
    logic           overflow;

    sram_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW),
        .SRAM_AW    (SAW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ce         (ce),
        .download   (download),
        .ioctl_wr   (ioctl_wr),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .vid_a      (vid_a),
        .vid_q      (vid_q),
        .sram_we_n  (sram_we_n),
        .sram_a     (sram_a),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending bytes, the byte being written and its progress
    // (0 = no write, 1..3 = cycles since the write slot began).
    logic [AW+7:0] q[$];
    logic [AW+7:0] cur = '0;
    int            age = 0;
    bit            ovf_seen = 0;
    bit            mvalid = 0;
    bit            m_pop;
    logic [AW-1:0] prev_vid = '0;
    logic [AW+7:0] obs[$];

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            age      = 0;
            ovf_seen = 0;
            prev_vid = vid_a;
            mvalid   = 1;
        end else begin
            m_pop = (age == 0) && ce && (q.size() > 0);
            if (m_pop) begin
                cur = q.pop_front();
                age = 1;
            end else if (age != 0) begin
                age = (age + 1) % 4;
            end
            if (download && ioctl_wr) begin
                if (q.size() < DEPTH) q.push_back({ioctl_addr, ioctl_dout});
                else ovf_seen = 1;
            end
            prev_vid = vid_a;
        end
    end

    always @(negedge clock) begin
        if (mvalid) begin
            chk("we_n", sram_we_n, (age == 2) ? 0 : 1);
            chk("oe", sram_dq_oe, age != 0);
            chk("addr", sram_a,
                (age != 0) ? {6'b0, cur[AW+7:8]} : {6'b0, prev_vid});
            if (age != 0) chk("wdata", sram_dq_o, cur[7:0]);
            chk("busy", busy, (q.size() != 0) || (age != 0));
            chk("overflow", overflow, OVF && ovf_seen);
            chk("vid_q", vid_q, sram_dq_i);
            if (ce) begin
                chk("slot_oe", sram_dq_oe, 0);
                chk("slot_we", sram_we_n, 1);
                chk("slot_addr", sram_a, {6'b0, vid_a});
            end
            if (!sram_we_n) obs.push_back({sram_a[AW-1:0], sram_dq_o});
        end
    end

    // vid_a only changes right after the video slot, so it is stable
    // through the cycle before ce and the ce cycle itself.
    task automatic cycle();
        @(posedge clock);
        #1;
        cnt++;
        ce = (cnt % 4 == 0);
        if (cnt % 4 == 1) vid_a = AW'($urandom);
        sram_dq_i = 8'($urandom);
    endtask

    task automatic align(input int k);
        while (cnt % 4 != k) cycle();
    endtask

    initial begin
        repeat (3) cycle();
        @(negedge clock);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe", sram_dq_oe, 0);
        chk("rst_dq_o", sram_dq_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", sram_a, {6'b0, vid_a});
        cycle();
        reset = 1'b0;
        repeat (4) cycle();

        // single byte just before the video slot
        download = 1'b1;
        align(3);
        ioctl_wr   = 1'b1;
        ioctl_addr = 15'h1A00;
        ioctl_dout = 8'h5C;
        cycle();
        ioctl_wr = 1'b0;
        @(negedge clock);
        chk("t1_ce_busy", busy, 1);
        chk("t1_ce_oe", sram_dq_oe, 0);
        cycle();
        @(negedge clock);
        chk("t1_setup_oe", sram_dq_oe, 1);
        chk("t1_setup_we", sram_we_n, 1);
        chk("t1_setup_a", sram_a, 21'h001A00);
        cycle();
        @(negedge clock);
        chk("t1_strobe_we", sram_we_n, 0);
        chk("t1_strobe_a", sram_a, 21'h001A00);
        chk("t1_strobe_d", sram_dq_o, 8'h5C);
        cycle();
        @(negedge clock);
        chk("t1_hold_we", sram_we_n, 1);
        chk("t1_hold_oe", sram_dq_oe, 1);
        cycle();
        @(negedge clock);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_oe", sram_dq_oe, 0);

        // burst of four
        obs.delete();
        align(1);
        for (int i = 0; i < 4; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = AW'(32'h100 + i);
            ioctl_dout = 8'(32'hA0 + i);
            cycle();
        end
        ioctl_wr = 1'b0;
        repeat (20) cycle();
        chk("burst_n", obs.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < obs.size())
                chk("burst_w", obs[i], {AW'(32'h100 + i), 8'(32'hA0 + i)});
        chk("burst_ovf", overflow, 0);

        // six back-to-back: pushes 1..5 fit (one pop at ce), push 6 drops
        obs.delete();
        align(1);
        for (int i = 0; i < 6; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = AW'(32'h200 + i);
            ioctl_dout = 8'(32'h30 + i);
            cycle();
        end
        ioctl_wr = 1'b0;
        repeat (30) cycle();
        chk("ovf_n", obs.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < obs.size())
                chk("ovf_w", obs[i], {AW'(32'h200 + i), 8'(32'h30 + i)});
        chk("ovf_flag", overflow, OVF);

        // reset during STROBE with one byte still buffered
        align(2);
        ioctl_wr   = 1'b1;
        ioctl_addr = 15'h0333;
        ioctl_dout = 8'h11;
        cycle();
        ioctl_addr = 15'h0444;
        ioctl_dout = 8'h22;
        cycle();
        ioctl_wr = 1'b0;
        cycle();
        cycle();
        @(negedge clock);
        chk("rmw_pre_we", sram_we_n, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("rmw_we", sram_we_n, 1);
        chk("rmw_oe", sram_dq_oe, 0);
        chk("rmw_busy", busy, 0);
        chk("rmw_ovf", overflow, 0);
        obs.delete();
        repeat (16) cycle();
        chk("rmw_nowrite", obs.size(), 0);

        // ioctl_wr without download
        download   = 1'b0;
        ioctl_wr   = 1'b1;
        ioctl_addr = 15'h0555;
        cycle();
        ioctl_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("ign_busy", busy, 0);
            cycle();
        end
        chk("ign_nowrite", obs.size(), 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            download   = ($urandom_range(0, 9) != 0);
            ioctl_wr   = ($urandom_range(0, 2) == 0);
            ioctl_addr = AW'($urandom);
            ioctl_dout = 8'($urandom);
            cycle();
        end
        download = 1'b0;
        ioctl_wr = 1'b0;
        repeat (30) cycle();
        @(negedge clock);
        chk("end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sits between the SPI download engine and the external 8-bit asynchronous SRAM, in front of the video fetch path. Buffers download byte writes in a small FIFO and performs timed SRAM write cycles only in the bus slots the video fetcher leaves free. The SRAM address therefore never changes under a video fetch. Video reads always own the bus on the `ce` cycle, so a download can run while the picture is being displayed.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: download byte buffer entries; must be a power of 2, ≥2.
- `ADDR_W`, 15: logical address width (download and video).
- `SRAM_AW`, 21: physical SRAM address width; upper bits are driven 0.

Ports:
- `clock`  in  1  28 MHz system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ce`  in  1  video fetch strobe; one cycle high in every 4, fixed phase.
- `download`  in  1  download in progress; pushes are accepted only while high.
- `ioctl_wr`  in  1  single-cycle byte-write strobe.
- `ioctl_addr`  in  ADDR_W  download byte address.
- `ioctl_dout`  in  8  download byte.
- `vid_a`  in  ADDR_W  video fetch address.
- `vid_q`  out  8  video data; combinational copy of `sram_dq_i`.
- `sram_we_n`  out  1  SRAM write enable, active-low.
- `sram_a`  out  SRAM_AW  SRAM address.
- `sram_dq_o`  out  8  SRAM write data.
- `sram_dq_oe`  out  1  data bus output enable; the top level tri-states on 0.
- `sram_dq_i`  in  8  SRAM read data.
- `busy`  out  1  FIFO not empty or write sequence active.
- `overflow`  out  1  sticky flag: a push was dropped (see Configuration).

## Operation
- Push: `download & ioctl_wr`. If the FIFO has room, {addr, byte} is stored. If the FIFO is full and a pop happens in the same cycle, the push is accepted. Otherwise the push is dropped.
- `ioctl_wr` while `download`=0 is ignored. FIFO draining continues regardless of `download`.
- Write FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
  - IDLE→SETUP only in the cycle after `ce`, and only with the FIFO not empty. The FIFO head pops on that transition edge.
  - SETUP: `sram_a` = write address, `sram_dq_oe`=1, `sram_we_n`=1.
  - STROBE: `sram_we_n`=0, with address and data held.
  - HOLD: `sram_we_n`=1, with address and data held.
  - HOLD→IDLE unconditionally.
- IDLE: `sram_a` = {0, `vid_a`}, `sram_dq_oe`=0, `sram_we_n`=1.
- One byte is written per `ce` period. Maximum drain rate is 7 MB/s.
- `busy` = FIFO not empty, or state ≠ IDLE.
- All SRAM control outputs are registered. `sram_a` upper `SRAM_AW-ADDR_W` bits are always 0.

## Timing
- Video slot: the `ce` cycle is always IDLE, so `vid_q` is valid from the SRAM for the whole `ce` cycle.
- Write latency: a push at cycle t is written (STROBE) no later than t+6, provided the FIFO was empty.
- `overflow` sets the cycle after a dropped push.
- Reset values: state IDLE, FIFO empty, `sram_we_n`=1, `sram_dq_oe`=0, `sram_dq_o`=0, `busy`=0, `overflow`=0, `sram_a`={0,`vid_a`} after the first clock.
- Reset during SETUP/STROBE/HOLD: IDLE on the next cycle, `sram_we_n` deasserted immediately, and buffered bytes are discarded.
- `download` falling with the FIFO non-empty: remaining entries still drain and `busy` stays high until done.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Full/empty are distinguished by an extra pointer bit.

## Configuration
- `SRAM_ARB_OVF_EN` defined: the sticky `overflow` flag is compiled in. It is cleared only by `reset`.
- Not defined: `overflow` is tied to 0 and dropped pushes are silent.
- FIFO and write behaviour are identical in both cases.

## Structure
- Package `sram_arb_pkg`:
  - FSM state encoding: IDLE=0, SETUP=1, STROBE=2, HOLD=3.
  - FIFO entry width, `ADDR_W+8`.
- Sub-module `sram_arb_fifo`: synchronous FIFO with push/pop/full/empty, used for the {addr, data} buffer.
- The top of the block contains the FSM and the SRAM bus muxing.

## Test plan
- Single byte: `download`=1, push addr 0x1A00 data 0x5C just before `ce` → SETUP/STROBE/HOLD in the 3 cycles after `ce`, with `sram_a`=0x001A00 and `sram_dq_o`=0x5C during STROBE, then `busy`=0.
- Video isolation: continuous push stream; on every `ce` cycle check `sram_dq_oe`=0, `sram_we_n`=1 and `sram_a`={0,`vid_a`}.
- Burst: 4 pushes on consecutive cycles with an empty FIFO → all 4 written in order over the next 4 `ce` periods, and `overflow`=0.
- Overflow: 6 back-to-back pushes with `FIFO_DEPTH`=4 → the excess pushes are dropped.
  - With `SRAM_ARB_OVF_EN`: `overflow`=1.
  - Without it: `overflow`=0.
  - The written bytes match the accepted entries.
- Reset mid-write: assert `reset` during STROBE → next cycle `sram_we_n`=1, `sram_dq_oe`=0, `busy`=0, and no further writes occur.
- Ignored write: `ioctl_wr` pulse with `download`=0 → no FIFO push and `busy` stays 0.
